// File: rtl/residual_add_pack_if.sv
// residual_add_pack_if: stream-in / packed-frame-out bundle for residual_add_pack
// master drives start and the two element streams; slave returns in_ready and the packed frame status.
interface residual_add_pack_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN = 8,
  parameter int EMB_DIM = 8
);
  localparam int N = SEQ_LEN * EMB_DIM;
  localparam int CW = $clog2(N + 1);
  logic start;
  logic a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic in_ready;
  logic [DATA_WIDTH*N-1:0] x_out;
  logic out_valid;
  logic done;
  logic [CW-1:0] sat_count;
  modport master (
    output start, a_valid, a_data, b_valid, b_data,
    input in_ready, x_out, out_valid, done, sat_count
  );
  modport slave (
    input start, a_valid, a_data, b_valid, b_data,
    output in_ready, x_out, out_valid, done, sat_count
  );
endinterface

// File: rtl/residual_add_pack.sv
// residual_add_pack: saturating add of sublayer and skip streams, packed row-major for layer norm
// Ports: clk; rst_n (async, active-low); bus (slave) carries start, a/b valid+data in and
//   in_ready, x_out, out_valid, done, sat_count out.
module residual_add_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN = 8,
  parameter int EMB_DIM = 8
) (
  input logic clk,
  input logic rst_n,
  residual_add_pack_if.slave bus
);
  localparam int N = SEQ_LEN * EMB_DIM;
  localparam int CW = $clog2(N + 1);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int RW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  localparam int LW = EMB_DIM > 1 ? $clog2(EMB_DIM) : 1;
  typedef enum logic {S_IDLE, S_FILL} state_t;
  state_t r_state, w_next;
  logic [RW-1:0] r_row;
  logic [LW-1:0] r_col;
  logic [DATA_WIDTH-1:0] r_x [N];
  logic [CW-1:0] r_sat;
  logic r_out_valid, r_done;
  logic w_acc, w_clear, w_last, w_ovf;
  logic [IW-1:0] w_idx;
  logic [DATA_WIDTH:0] w_ext;
  logic [DATA_WIDTH-1:0] w_res;
  always_comb begin
    w_acc = r_state == S_FILL && bus.a_valid && bus.b_valid;
    w_clear = r_state == S_IDLE && bus.start;
    w_last = r_row == RW'(SEQ_LEN - 1) && r_col == LW'(EMB_DIM - 1);
    w_idx = IW'(r_row) * IW'(EMB_DIM) + IW'(r_col);
    w_ext = {bus.a_data[DATA_WIDTH-1], bus.a_data} + {bus.b_data[DATA_WIDTH-1], bus.b_data};
    // the sum left the DATA_WIDTH range exactly when the two top bits of the extended sum differ;
    // the extra top bit then gives the direction of the overflow
    w_ovf = w_ext[DATA_WIDTH] ^ w_ext[DATA_WIDTH-1];
    w_res = w_ovf ? {w_ext[DATA_WIDTH], {(DATA_WIDTH-1){~w_ext[DATA_WIDTH]}}} : w_ext[DATA_WIDTH-1:0];
    w_next = r_state == S_IDLE ? (bus.start ? S_FILL : S_IDLE) : (w_acc && w_last ? S_IDLE : S_FILL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_sat <= '0;
      r_out_valid <= 1'b0;
      r_done <= 1'b0;
      for (int k = 0; k < N; k++) r_x[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_clear) begin
        r_row <= '0;
        r_col <= '0;
        r_sat <= '0;
        r_out_valid <= 1'b0;
        for (int k = 0; k < N; k++) r_x[k] <= '0;
      end else if (w_acc) begin
        for (int k = 0; k < N; k++) if (w_idx == IW'(k)) r_x[k] <= w_res;
        if (w_ovf) r_sat <= r_sat + CW'(1);
        if (w_last) begin
          r_row <= '0;
          r_col <= '0;
          r_done <= 1'b1;
          r_out_valid <= 1'b1;
        end else if (r_col == LW'(EMB_DIM - 1)) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + LW'(1);
        end
      end
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_pack
    assign bus.x_out[k*DATA_WIDTH +: DATA_WIDTH] = r_x[k];
  end
  assign bus.in_ready = r_state == S_FILL;
  assign bus.out_valid = r_out_valid;
  assign bus.done = r_done;
  assign bus.sat_count = r_sat;
endmodule

// File: tb/tb_residual_add_pack.sv
// tb_residual_add_pack: table and scoreboard checks of residual_add_pack framing, saturation and reset
module tb_residual_add_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0, n_total = 0, n_done = 0, cyc = 0, t0 = 0, exp_sat = 0;
  logic [15:0] q_exp [$];
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e;
    bit s;
  } vec_t;
  vec_t tbl [8];
  residual_add_pack_if bus ();
  residual_add_pack dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.done) n_done++;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  function automatic void model(input logic [15:0] a, input logic [15:0] b, output logic [15:0] e, output bit s);
    int t;
    t = int'($signed(a)) + int'($signed(b));
    s = (t > 32767) || (t < -32768);
    e = t > 32767 ? 16'h7fff : (t < -32768 ? 16'h8000 : t[15:0]);
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic begin_frame();
    q_exp.delete();
    exp_sat = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc;
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e, input bit s);
    int w = 0;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data = a;
    bus.b_data = b;
    while (!bus.in_ready && w < 8) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) check("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    q_exp.push_back(e);
    exp_sat += int'(s);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask
  task automatic send_m(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] e;
    bit s;
    model(a, b, e, s);
    send(a, b, e, s);
  endtask
  task automatic end_frame(input string tag);
    check({tag, "_done"}, 64'(bus.done), 1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 1);
    check({tag, "_sat_count"}, 64'(bus.sat_count), 64'(exp_sat));
    check({tag, "_pairs"}, 64'(q_exp.size()), 64);
    for (int i = 0; i < 64 && q_exp.size() > 0; i++)
      check($sformatf("%s_word%0d", tag, i), 64'(bus.x_out[i*16 +: 16]), 64'(q_exp.pop_front()));
  endtask
  initial begin
    logic [1023:0] snap;
    int nd;
    bus.start = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data = '0;
    bus.b_data = '0;
    tbl[0] = '{16'h7000, 16'h7000, 16'h7fff, 1'b1};
    tbl[1] = '{16'h8000, 16'hffff, 16'h8000, 1'b1};
    tbl[2] = '{16'h7fff, 16'h0000, 16'h7fff, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 1'b1};
    tbl[4] = '{16'hffff, 16'h0001, 16'h0000, 1'b0};
    tbl[5] = '{16'h7fff, 16'h0001, 16'h7fff, 1'b1};
    tbl[6] = '{16'h8001, 16'hffff, 16'h8000, 1'b0};
    tbl[7] = '{16'h1234, 16'h0f00, 16'h2134, 1'b0};
    idle(2);
    check("rst_x_out_zero", 64'(bus.x_out == '0), 1);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_sat_count", 64'(bus.sat_count), 0);
    rst_n = 1'b1;
    idle(1);
    check("idle_in_ready", 64'(bus.in_ready), 0);
    begin_frame();
    check("fill_in_ready", 64'(bus.in_ready), 1);
    for (int i = 0; i < 64; i++) send_m(16'(i), 16'd1);
    end_frame("ramp");
    check("ramp_latency", 64'(cyc - t0), 64);
    idle(2);
    check("ramp_done_low", 64'(bus.done), 0);
    check("ramp_out_valid_hold", 64'(bus.out_valid), 1);
    begin_frame();
    for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].s);
    for (int i = 8; i < 64; i++) send_m(16'(i), 16'(i));
    end_frame("sat");
    begin_frame();
    check("restart_out_valid", 64'(bus.out_valid), 0);
    check("restart_sat_count", 64'(bus.sat_count), 0);
    check("restart_x_out_zero", 64'(bus.x_out == '0), 1);
    for (int i = 0; i < 64; i++) begin
      if (i == 3 || i == 30) begin
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b0;
        bus.a_data = 16'h5555;
        idle(3);
        bus.a_valid = 1'b0;
      end
      if (i == 5 || i == 40) send_m(16'h7000, 16'h7000);
      else send_m(16'(i), 16'd0);
    end
    end_frame("bubble");
    check("bubble_sat_two", 64'(bus.sat_count), 2);
    idle(2);
    begin_frame();
    for (int i = 0; i < 64; i++) begin
      if (i == 10) bus.start = 1'b1;
      send_m(16'(i), 16'd100);
      bus.start = 1'b0;
      if (i == 10) check("startfill_in_ready", 64'(bus.in_ready), 1);
    end
    end_frame("startfill");
    idle(2);
    begin_frame();
    for (int i = 0; i < 20; i++) send_m(16'(i), 16'd7);
    nd = n_done;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_x_out_zero", 64'(bus.x_out == '0), 1);
    check("midrst_out_valid", 64'(bus.out_valid), 0);
    check("midrst_done", 64'(bus.done), 0);
    check("midrst_sat_count", 64'(bus.sat_count), 0);
    check("midrst_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("midrst_no_done", 64'(n_done), 64'(nd));
    begin_frame();
    for (int i = 0; i < 64; i++) send_m(16'hfffb, 16'h0002);
    end_frame("neg");
    snap = bus.x_out;
    idle(3);
    check("final_done_low", 64'(bus.done), 0);
    check("final_out_valid_hold", 64'(bus.out_valid), 1);
    check("final_x_out_stable", 64'(bus.x_out == snap), 1);
    check("final_word0", 64'(bus.x_out[15:0]), 64'h fffd);
    check("done_pulse_count", 64'(n_done), 5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
